// File: rtl/pc_stack.sv
// pc_stack: fetch-stage program counter with relative branches, a hardware
// return-address stack for CALL/RET, fetch stall and sticky stack-error flags.
module pc_stack #(
  parameter int             W        = 8,
  parameter int             DEPTH    = 4,
  parameter logic [W-1:0]   RESET_PC = '0,
  localparam int            SPW      = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall,
  input  logic [2:0]     op,
  input  logic [W-1:0]   target,
  input  logic [W-1:0]   offset,
  input  logic           cond,
  input  logic           clr_err,
  output logic [W-1:0]   pc,
  output logic [SPW-1:0] sp,
  output logic           full,
  output logic           empty,
  output logic           ovf,
  output logic           unf
);

  // Stack slot index width; a one-entry stack still needs a one-bit index.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BR   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic [W-1:0]   stack_mem [DEPTH];
  logic [W-1:0]   pc_inc;
  logic [W-1:0]   pc_next;
  logic [SPW-1:0] sp_next;
  logic [SPW-1:0] sp_dec;
  logic [AW-1:0]  push_idx;
  logic [AW-1:0]  top_idx;
  logic           ovf_next;
  logic           unf_next;
  logic           push;

  assign pc_inc   = pc + W'(1);
  assign sp_dec   = sp - SPW'(1);
  assign push_idx = sp[AW-1:0];
  assign top_idx  = sp_dec[AW-1:0];
  assign full     = (sp == SPW'(DEPTH));
  assign empty    = (sp == '0);

  // Next pc, stack pointer and flags; stall freezes everything, and a flag
  // set in the same cycle as clr_err overrides the clear.
  always_comb begin
    pc_next  = pc;
    sp_next  = sp;
    ovf_next = ovf;
    unf_next = unf;
    push     = 1'b0;
    if (!stall) begin
      if (clr_err) begin
        ovf_next = 1'b0;
        unf_next = 1'b0;
      end
      case (op)
        OP_JMP: pc_next = target;
        OP_BR:  pc_next = cond ? (pc + offset) : pc_inc;
        OP_CALL: begin
          if (!full) begin
            push    = 1'b1;
            sp_next = sp + SPW'(1);
            pc_next = target;
          end else begin
            pc_next  = pc_inc;
            ovf_next = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            sp_next = sp_dec;
            pc_next = stack_mem[top_idx];
          end else begin
            pc_next  = pc_inc;
            unf_next = 1'b1;
          end
        end
        default: pc_next = pc_inc;
      endcase
    end
  end

  // Architectural state: pc, stack pointer and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      pc  <= pc_next;
      sp  <= sp_next;
      ovf <= ovf_next;
      unf <= unf_next;
    end
  end

  // Return-address storage; contents are meaningless after reset, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule
